// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding and segment constants for seg_scan_sched
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to active-low 7-segment decode with blanking
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - 4-digit 7-seg scan scheduler with frame-aligned double buffering
// Optional SEG_DIMMING_EN adds a bright[2:0] port that gates anode on-time within each slot.
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int LZ_SUPP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [1:0]  dp_sel,
  input  logic        dp_en,
`ifdef SEG_DIMMING_EN
  input  logic [2:0]  bright,
`endif
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);

  // At least 8 bits so the dimming compare on cnt[7:5] is always in range
  localparam int CW = ($clog2(TICK_DIV) > 8) ? $clog2(TICK_DIV) : 8;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     idx, idx_n;
  logic [15:0]    shadow_d, active_d;
  logic [1:0]     shadow_sel, active_sel;
  logic           shadow_en, active_en;
  logic           boundary;
  logic [3:0]     nibble;
  logic           zero_above, dp_above, dp_hit, lz_blank;
  logic [6:0]     seg_dec, seg_n;
  logic [3:0]     anode_n;
  logic           dp_n;
`ifdef SEG_DIMMING_EN
  logic [2:0]     bright_q;
`endif

  assign boundary = (state == SHOW) && (cnt == CNT_LAST) && (idx == 2'd3);

  assign nibble     = 4'(active_d >> {idx, 2'b00});
  assign zero_above = (active_d >> {idx, 2'b00}) == 16'h0000;
  assign dp_hit     = active_en && (active_sel == idx);
  assign dp_above   = active_en && (active_sel >= idx);
  assign lz_blank   = (LZ_SUPP != 0) && (idx != 2'd0) && zero_above && !dp_above;

  hex7seg u_hex7seg (
    .nibble (nibble),
    .blank  (lz_blank),
    .seg    (seg_dec)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    case (state)
      BLANK: if (cnt == BLANK_END) state_n = SHOW;
      SHOW: begin
        if (cnt == CNT_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
        end
      end
      default: state_n = BLANK;
    endcase
  end

  // Outputs are computed from the next state so they switch on the same edge as the FSM
  always_comb begin
    anode_n = ANODE_OFF;
    seg_n   = SEG_BLANK;
    dp_n    = 1'b1;
    if (state_n == SHOW) begin
      anode_n = ~(4'b0001 << idx_n);
      seg_n   = seg_dec;
      dp_n    = ~dp_hit;
`ifdef SEG_DIMMING_EN
      if (cnt_n[7:5] > bright_q) anode_n = ANODE_OFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      anode      <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      shadow_d   <= 16'h0000;
      shadow_sel <= 2'd0;
      shadow_en  <= 1'b0;
      active_d   <= 16'h0000;
      active_sel <= 2'd0;
      active_en  <= 1'b0;
`ifdef SEG_DIMMING_EN
      bright_q   <= 3'd0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      anode      <= anode_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_done <= boundary;
      if (load) begin
        shadow_d   <= digits_in;
        shadow_sel <= dp_sel;
        shadow_en  <= dp_en;
      end
      // A load on the boundary edge keeps the new word pending while the old shadow commits
      if (load) pending <= 1'b1;
      else if (boundary) pending <= 1'b0;
      if (boundary && pending) begin
        active_d   <= shadow_d;
        active_sel <= shadow_sel;
        active_en  <= shadow_en;
      end
`ifdef SEG_DIMMING_EN
      if (boundary) bright_q <= bright;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb/tb_seg_scan_sched.sv - directed self-checking bench for seg_scan_sched
module tb_seg_scan_sched;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [1:0]  dp_sel = 2'd0;
  logic        dp_en = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp, pending, frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_sched #(.TICK_DIV(8), .BLANK_CYC(2), .LZ_SUPP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .dp_sel     (dp_sel),
    .dp_en      (dp_en),
`ifdef SEG_DIMMING_EN
    .bright     (3'd7),
`endif
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] w, input logic en, input logic [1:0] sel);
    digits_in = w;
    dp_en     = en;
    dp_sel    = sel;
    load      = 1'b1;
    tick(1);
    load      = 1'b0;
    dp_en     = 1'b0;
  endtask

  // segs = {d3,d2,d1,d0}; returns positioned at the last cycle (31) of the captured frame
  task automatic capture(input logic [27:0] segs, input int dp_slot, input logic exp_pend);
    int waited = 0;
    while (frame_done !== 1'b1 && waited < 64) begin
      tick(1);
      waited++;
    end
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    check("pending_at_frame", {31'd0, pending}, {31'd0, exp_pend});
    for (int c = 0; c < 32; c++) begin
      int slot = c / 8;
      int k = c % 8;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      if (c > 0) tick(1);
      ea = (k < 2) ? 4'hF : ~(4'b0001 << slot);
      es = (k < 2) ? 7'h7F : segs[slot*7 +: 7];
      ed = !(k >= 2 && slot == dp_slot);
      check($sformatf("anode_c%0d", c), {28'd0, anode}, {28'd0, ea});
      check($sformatf("seg_c%0d", c), {25'd0, seg}, {25'd0, es});
      check($sformatf("dp_c%0d", c), {31'd0, dp}, {31'd0, ed});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("anode_onecold",
            (anode == 4'hF || anode == 4'hE || anode == 4'hD || anode == 4'hB || anode == 4'h7) ? 32'd1 : 32'd0,
            32'd1);
      if (dut.state == BLANK) check("anode_off_in_blank", {28'd0, anode}, 32'hF);
    end
  end

  initial begin
    // 1: reset state, reset mid-SHOW, restart timing
    tick(2);
    check("rst_anode", {28'd0, anode}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    tick(5);
    check("pre_rst_show", {28'd0, anode}, 32'hE);
    rst = 1'b1;
    #1;
    check("async_rst_anode", {28'd0, anode}, 32'hF);
    check("async_rst_seg", {25'd0, seg}, 32'h7F);
    check("async_rst_dp", {31'd0, dp}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    check("restart_blank", {28'd0, anode}, 32'hF);
    tick(1);
    check("restart_show", {28'd0, anode}, 32'hE);
    check("restart_seg0", {25'd0, seg}, 32'h40);

    // 2: free run with 1234
    do_load(16'h1234, 1'b0, 2'd0);
    check("load_pending", {31'd0, pending}, 32'd1);
    capture({7'h79, 7'h24, 7'h30, 7'h19}, -1, 1'b0);
    tick(1);
    check("frame_period", {31'd0, frame_done}, 32'd1);

    // 3: mid-frame load keeps old digits until the frame boundary
    tick(4);
    do_load(16'h0A07, 1'b0, 2'd0);
    check("mid_load_pending", {31'd0, pending}, 32'd1);
    tick(5);
    check("old_digit1_anode", {28'd0, anode}, 32'hD);
    check("old_digit1_seg", {25'd0, seg}, 32'h30);
    capture({7'h7F, 7'h08, 7'h40, 7'h78}, -1, 1'b0);

    // 4: two loads in one frame, last wins
    tick(4);
    do_load(16'h1111, 1'b0, 2'd0);
    tick(5);
    do_load(16'h2222, 1'b0, 2'd0);
    capture({7'h24, 7'h24, 7'h24, 7'h24}, -1, 1'b0);

    // 5: decimal point keeps zero digits below it visible
    tick(4);
    do_load(16'h0005, 1'b1, 2'd2);
    capture({7'h7F, 7'h40, 7'h40, 7'h12}, 2, 1'b0);

    // 6: load coincident with the frame boundary
    tick(3);
    do_load(16'h00C3, 1'b0, 2'd0);
    tick(28);
    check("boundary_align", {28'd0, anode}, 32'h7);
    check("boundary_pending", {31'd0, pending}, 32'd1);
    do_load(16'hFEDC, 1'b0, 2'd0);
    check("coincide_frame_done", {31'd0, frame_done}, 32'd1);
    check("coincide_pending", {31'd0, pending}, 32'd1);
    capture({7'h7F, 7'h7F, 7'h46, 7'h30}, -1, 1'b1);
    capture({7'h0E, 7'h06, 7'h21, 7'h46}, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
